// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Imported by if_stage and its IF/ID register.
package if_stage_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [6:0] op_of(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [2:0] f3_of(input logic [31:0] i);
    return i[14:12];
  endfunction

  function automatic logic [6:0] f7_of(input logic [31:0] i);
    return i[31:25];
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over flush, flush over stall.
// A non-stalled cycle with no load turns into a bubble (PC kept).
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_WORD
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     flush,
  input  logic     stall,
  input  if_word_t word_i,
  output if_id_t   q_o
);

  if_id_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d.pc    = word_i.pc;
      q_d.instr = word_i.instr;
      q_d.valid = 1'b1;
    end else if (flush || !stall) begin
      q_d.instr = NOP;
      q_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q.pc    <= '0;
      q_q.instr <= NOP;
      q_q.valid <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem handshake,
// stall hold buffer, redirect kill, and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        ID_Stall,
  input  logic        ID_Flush,
  input  logic        MEM_Redirect,
  input  logic [31:0] MEM_RedirectPC,
  output logic [31:0] IF_PC_ID,
  output logic [31:0] IF_Instr_ID,
  output logic [6:0]  IF_Op_ID,
  output logic [2:0]  IF_f3_ID,
  output logic [6:0]  IF_f7_ID,
  output logic        IF_Valid_ID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  if_word_t     hold_q, hold_d;
  logic         ifid_load, ifid_flush;
  if_word_t     ifid_word;
  if_id_t       ifid;
  logic         unused_pc_lsb;

  assign unused_pc_lsb = ^MEM_RedirectPC[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    hold_d    = hold_q;
    ifid_load = 1'b0;
    ifid_word = hold_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
          kill_d  = MEM_Redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          // pc_q already advanced past this word at grant
          if (!kill_q && !MEM_Redirect) begin
            if (ID_Stall) begin
              hold_d.pc    = pc_q - 32'd4;
              hold_d.instr = imem_rdata;
              state_d      = S_HOLD;
            end else begin
              ifid_load       = 1'b1;
              ifid_word.pc    = pc_q - 32'd4;
              ifid_word.instr = imem_rdata;
            end
          end
        end else if (MEM_Redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (MEM_Redirect) begin
          state_d = S_REQ;
        end else if (!ID_Stall) begin
          ifid_load = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (MEM_Redirect) pc_d = {MEM_RedirectPC[31:2], 2'b00};
    ifid_flush = MEM_Redirect | ID_Flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .flush  (ifid_flush),
    .stall  (ID_Stall),
    .word_i (ifid_word),
    .q_o    (ifid)
  );

  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign IF_PC_ID    = ifid.pc;
  assign IF_Instr_ID = ifid.instr;
  assign IF_Valid_ID = ifid.valid;
  assign IF_Op_ID    = op_of(ifid.instr);
  assign IF_f3_ID    = f3_of(ifid.instr);
  assign IF_f7_ID    = f7_of(ifid.instr);

  assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> state_q == S_WAIT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small latency-configurable
// instruction memory responder driven from the step task.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ID_Stall;
  logic        ID_Flush;
  logic        MEM_Redirect;
  logic [31:0] MEM_RedirectPC;
  logic [31:0] IF_PC_ID;
  logic [31:0] IF_Instr_ID;
  logic [6:0]  IF_Op_ID;
  logic [2:0]  IF_f3_ID;
  logic [6:0]  IF_f7_ID;
  logic        IF_Valid_ID;

  int checks = 0;
  int errors = 0;

  bit          gnt_en;
  int          lat;
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ID_Stall       (ID_Stall),
    .ID_Flush       (ID_Flush),
    .MEM_Redirect   (MEM_Redirect),
    .MEM_RedirectPC (MEM_RedirectPC),
    .IF_PC_ID       (IF_PC_ID),
    .IF_Instr_ID    (IF_Instr_ID),
    .IF_Op_ID       (IF_Op_ID),
    .IF_f3_ID       (IF_f3_ID),
    .IF_f7_ID       (IF_f7_ID),
    .IF_Valid_ID    (IF_Valid_ID)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a << 8) | 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Grant decided late in the cycle; data returns lat cycles later.
  task automatic step();
    #1;
    imem_gnt = gnt_en && imem_req && !pend;
    if (imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = lat;
    end
    @(posedge clk);
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend_addr);
        pend        = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    ID_Stall = 1'b0;
    ID_Flush = 1'b0;
    MEM_Redirect = 1'b0;
    MEM_RedirectPC = '0;
    gnt_en = 1'b1;
    lat = 1;
    pend = 1'b0;
    cnt = 0;
    pend_addr = '0;

    step();
    chk("rst_instr", IF_Instr_ID, 32'h13);
    chk("rst_pc", IF_PC_ID, 32'h0);
    chk("rst_valid", {31'b0, IF_Valid_ID}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("req0", {31'b0, imem_req}, 32'h1);
    chk("addr0", imem_addr, 32'h0);

    step();
    chk("wait_req", {31'b0, imem_req}, 32'h0);
    chk("wait_valid", {31'b0, IF_Valid_ID}, 32'h0);
    step();
    chk("lat_valid", {31'b0, IF_Valid_ID}, 32'h1);
    chk("lat_pc", IF_PC_ID, 32'h0);
    chk("w0_instr", IF_Instr_ID, 32'h00A0_0093);
    chk("w0_op", {25'b0, IF_Op_ID}, 32'h13);
    chk("w0_f3", {29'b0, IF_f3_ID}, 32'h0);
    chk("w0_f7", {25'b0, IF_f7_ID}, 32'h0);
    chk("addr4", imem_addr, 32'h4);
    step();
    chk("pulse_valid", {31'b0, IF_Valid_ID}, 32'h0);
    chk("bub_instr", IF_Instr_ID, 32'h13);
    chk("bub_pc", IF_PC_ID, 32'h0);
    step();
    chk("w4_valid", {31'b0, IF_Valid_ID}, 32'h1);
    chk("w4_pc", IF_PC_ID, 32'h4);
    chk("w4_instr", IF_Instr_ID, 32'h0000_0413);
    chk("addr8", imem_addr, 32'h8);

    ID_Stall = 1'b1;
    step();
    step();
    chk("stl_pc1", IF_PC_ID, 32'h4);
    chk("stl_req1", {31'b0, imem_req}, 32'h0);
    step();
    chk("stl_pc2", IF_PC_ID, 32'h4);
    chk("stl_val2", {31'b0, IF_Valid_ID}, 32'h1);
    chk("stl_req2", {31'b0, imem_req}, 32'h0);
    ID_Stall = 1'b0;
    step();
    chk("rel_pc", IF_PC_ID, 32'h8);
    chk("rel_instr", IF_Instr_ID, 32'h0000_0813);
    chk("rel_valid", {31'b0, IF_Valid_ID}, 32'h1);
    chk("addr12", imem_addr, 32'hC);

    lat = 2;
    step();
    MEM_Redirect = 1'b1;
    MEM_RedirectPC = 32'h0000_0103;
    step();
    MEM_Redirect = 1'b0;
    lat = 1;
    chk("rw_valid1", {31'b0, IF_Valid_ID}, 32'h0);
    chk("rw_req1", {31'b0, imem_req}, 32'h0);
    step();
    chk("rw_req", {31'b0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h100);
    chk("rw_valid2", {31'b0, IF_Valid_ID}, 32'h0);
    step();
    chk("rw_valid3", {31'b0, IF_Valid_ID}, 32'h0);
    step();
    chk("t100_valid", {31'b0, IF_Valid_ID}, 32'h1);
    chk("t100_pc", IF_PC_ID, 32'h100);
    chk("t100_instr", IF_Instr_ID, 32'h0001_0013);

    MEM_Redirect = 1'b1;
    MEM_RedirectPC = 32'h0000_0200;
    step();
    MEM_Redirect = 1'b0;
    chk("rg_valid1", {31'b0, IF_Valid_ID}, 32'h0);
    step();
    chk("rg_req", {31'b0, imem_req}, 32'h1);
    chk("rg_addr", imem_addr, 32'h200);
    chk("rg_valid2", {31'b0, IF_Valid_ID}, 32'h0);
    chk("rg_pc", IF_PC_ID, 32'h100);
    step();
    step();
    chk("t200_pc", IF_PC_ID, 32'h200);
    chk("t200_instr", IF_Instr_ID, 32'h0002_0013);
    chk("t200_valid", {31'b0, IF_Valid_ID}, 32'h1);

    ID_Stall = 1'b1;
    ID_Flush = 1'b1;
    step();
    ID_Stall = 1'b0;
    ID_Flush = 1'b0;
    chk("fl_instr", IF_Instr_ID, 32'h13);
    chk("fl_valid", {31'b0, IF_Valid_ID}, 32'h0);
    chk("fl_pc", IF_PC_ID, 32'h200);
    step();
    chk("t204_pc", IF_PC_ID, 32'h204);
    chk("t204_valid", {31'b0, IF_Valid_ID}, 32'h1);

    gnt_en = 1'b0;
    MEM_Redirect = 1'b1;
    MEM_RedirectPC = 32'hFFFF_FFFF;
    step();
    MEM_Redirect = 1'b0;
    gnt_en = 1'b1;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_req", {31'b0, imem_req}, 32'h1);
    step();
    step();
    chk("wrap_pc", IF_PC_ID, 32'hFFFF_FFFC);
    chk("wrap_instr", IF_Instr_ID, 32'hFFFF_FC13);
    chk("wrap_f3", {29'b0, IF_f3_ID}, 32'h7);
    chk("wrap_f7", {25'b0, IF_f7_ID}, 32'h7F);
    chk("wrap_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
